// File: rtl/pulse_blinker.sv
// Event-driven LED blinker: each accepted pulse yields one ON_CYCLES blink followed by an
// OFF_CYCLES gap. Events arriving while busy are queued in a saturating pending counter.
module pulse_blinker #(
    parameter int unsigned ON_CYCLES  = 5000000,
    parameter int unsigned OFF_CYCLES = 5000000,
    parameter int unsigned PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned MaxCyc = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0]   OnLoad  = CntW'(ON_CYCLES - 1);
    localparam logic [CntW-1:0]   OffLoad = CntW'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PendMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              inc, dec;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        inc     = 1'b0;
        dec     = 1'b0;

        case (state_q)
            StIdle: begin
                if (pulse_in) begin
                    state_d = StOn;
                    cnt_d   = OnLoad;
                end
            end
            StOn: begin
                inc = pulse_in;
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = OffLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                inc = pulse_in;
                if (cnt_q == '0) begin
                    if (pend_q != '0 || pulse_in) begin
                        state_d = StOn;
                        cnt_d   = OnLoad;
                        dec     = (pend_q != '0);
                        // Nothing queued: a pulse on the final gap cycle starts the blink itself.
                        if (pend_q == '0) begin
                            inc = 1'b0;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (inc && !dec) begin
            if (pend_q == PendMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - 1'b1;
        end

        led_d  = (state_d == StOn);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_blinker.sv
// Bench for pulse_blinker: directed scenarios then random pulses/resets, checked every cycle
// against a schedule-of-blink-start-times reference model.
module tb_pulse_blinker;

    localparam int unsigned ON   = 3;
    localparam int unsigned OFF  = 2;
    localparam int unsigned PW   = 2;
    localparam int unsigned PMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse_in;
    logic          led;
    logic          busy;
    logic          overflow;
    logic [PW-1:0] pending;

    always #5 clk = ~clk;

    pulse_blinker #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .PEND_W    (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pulse_in(pulse_in),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;
    int t = 0;
    // Model: start cycle of every scheduled blink, first cycle the block is idle again.
    int starts[$];
    int busy_end = 0;
    bit m_ovf = 1'b0;

    function automatic int count_after(input int c);
        int n = 0;
        foreach (starts[i]) if (starts[i] > c) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    task automatic step(input logic p, input logic r);
        bit exp_led;
        pulse_in = p;
        rst      = r;
        @(posedge clk);
        #1;
        if (r) begin
            starts.delete();
            busy_end = 0;
            m_ovf    = 1'b0;
        end else if (p) begin
            if (t >= busy_end) begin
                starts.push_back(t + 1);
                busy_end = t + 1 + ON + OFF;
            end else if (count_after(t + 1) < PMAX) begin
                starts.push_back(busy_end);
                busy_end += ON + OFF;
            end else begin
                m_ovf = 1'b1;
            end
        end
        t++;
        while (starts.size() > 0 && starts[0] + ON + OFF <= t) void'(starts.pop_front());
        exp_led = 1'b0;
        foreach (starts[i]) if (starts[i] <= t && t < starts[i] + ON) exp_led = 1'b1;
        chk("led", int'(led), int'(exp_led));
        chk("busy", int'(busy), (t < busy_end) ? 1 : 0);
        chk("pending", int'(pending), count_after(t));
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    initial begin
        pulse_in = 1'b0;
        rst      = 1'b1;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("reset_idle", int'(busy), 0);
        repeat (8) step(1'b0, 1'b0);

        // Single event
        step(1'b1, 1'b0);
        chk("single_led_on", int'(led), 1);
        repeat (8) step(1'b0, 1'b0);

        // Queued event two cycles later
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("queued_pending", int'(pending), 1);
        repeat (12) step(1'b0, 1'b0);

        // Saturation: first consumed, three queued, fifth dropped
        repeat (5) step(1'b1, 1'b0);
        chk("sat_pending", int'(pending), 3);
        chk("sat_overflow", int'(overflow), 1);
        repeat (25) step(1'b0, 1'b0);
        chk("sat_sticky", int'(overflow), 1);
        chk("sat_done", int'(busy), 0);

        // Simultaneous increment and decrement on the last gap cycle
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("simul_pending", int'(pending), 1);
        chk("simul_led", int'(led), 1);
        chk("simul_overflow", int'(overflow), 0);
        repeat (15) step(1'b0, 1'b0);

        // Reset mid-blink with a queue and overflow pending
        repeat (5) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("rst_led", int'(led), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_overflow", int'(overflow), 0);
        repeat (10) step(1'b0, 1'b0);

        // Back-to-back pulses from idle
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("b2b_led", int'(led), 1);
        chk("b2b_pending", int'(pending), 1);
        repeat (15) step(1'b0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(4) == 0), ($urandom_range(99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
